uart_ctrl_bank: RTL and testbench
=================================

Name: uart_ctrl_bank

Overview:
- Multi-channel UART control register bank, a parametrised generalisation of the single-channel control core.
- Host side: byte-wide addressed write/read bus.
- Each channel holds two register sets:
  - a shadow set, written by the host;
  - an active set, which drives the baud generator, transmitter and receiver.
- Shadow-to-active transfer happens only on an explicit commit request, and only while the channel reports idle. Reconfiguration therefore never lands mid-frame.
- Commits carrying an illegal configuration are rejected and flagged.

Parameters:
- CH_NUM, 2: number of UART channels (1..8).
- DIV_W, 16: baud divisor width (9..16).
- DEF_PERIOD, 20: reset divisor.
- DEF_UP, 10: reset round-up acquisition count (4 bit).
- DEF_DOWN, 5: reset round-down acquisition count (4 bit).
- AW, 3+clog2(CH_NUM) (min 4): address width, derived, not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- wr_en_i  in  1  write strobe
- rd_en_i  in  1  read strobe
- addr_i  in  AW  {channel, reg[2:0]}
- wdata_i  in  8  write data
- rdata_o  out  8  read data, registered
- ch_idle_i  in  CH_NUM  per-channel idle (no frame in flight)
- baud_div_o  out  CH_NUM*DIV_W  active divisor, channel 0 in LSBs
- bit_comp_o  out  CH_NUM*8  active {up[3:0],down[3:0]}
- acq_num_o  out  CH_NUM*5  active up+down, 5 bit, no overflow
- parity_en_o  out  CH_NUM  active parity enable
- big_end_o  out  CH_NUM  active bit order, 1 = MSB first
- parity_odd_o  out  CH_NUM  active parity method, 1 = odd
- commit_o  out  CH_NUM  one-cycle pulse on successful commit
- err_o  out  CH_NUM  sticky commit-rejected flag

Behaviour:
- Register map per channel:
  - 0 ENC: bit7 big_end, bit6 parity_en, bit5 parity_odd; bits 4:0 ignored, read 0.
  - 1 DIV_LO.
  - 2 DIV_HI: bits above DIV_W-8 ignored on write, read 0.
  - 3 COMP: up[7:4], down[3:0].
  - 4 CMD: write bit0=1 requests commit; reads 0.
  - 5 STATUS: bit0 pending, bit1 err, bit2 locked. Writing bit1=1 clears err.
  - 6–7: reserved; writes ignored, read 0.
- Reset: shadow and active = defaults (divisor DEF_PERIOD, comp {DEF_UP,DEF_DOWN}, acq_num 15, parity_en 1, big_end 0, parity_odd 1). pending 0, err 0, commit_o 0, rdata_o 0.
- Writes to channel index >= CH_NUM are ignored; reads of it return 0.
- Shadow writes take effect on the write edge. Readback of regs 0–3 returns shadow, not active.
- Read latency is 1 cycle: rdata_o is valid the cycle after rd_en_i and holds until the next read.
- Simultaneous rd_en_i and wr_en_i to the same register returns the pre-write value.
- Per-channel FSM has two states, IDLE and PEND:
  - IDLE to PEND on a CMD write with bit0=1.
  - In PEND, at each edge where ch_idle_i[ch]=1, validate the shadow set.
  - Valid (divisor >= 2 and up+down != 0): copy shadow to active, compute acq_num = up+down (5 bit), pulse commit_o for 1 cycle, go to IDLE.
  - Invalid: active unchanged, err set, no commit_o, go to IDLE.
  - PEND persists indefinitely while ch_idle_i=0.
  - Shadow writes during PEND are allowed; the values present at the commit edge are used.
  - A CMD write during PEND is a no-op; no queueing.
- Latency: CMD write edge N sets pending. With ch_idle_i=1 at edge N+1, the active outputs and commit_o change after edge N+1.
- A CMD write and an err-clear in the same cycle cannot occur (distinct addresses).
- If a rejection coincides with a STATUS write of bit1=1, set wins.
- Reset mid-PEND: returns to IDLE with defaults. Channels are fully independent.

Optional Feature:
- Macro UART_CTRL_LOCK_EN.
- Defined:
  - CMD bit7=1 sets the channel lock; CMD bit6=1 clears it (bit6 wins if both are set).
  - While locked, writes to regs 0–3 and commit requests are ignored; an already-pending commit still completes.
  - STATUS bit2 reflects the lock. Lock resets to 0.
- Undefined: CMD bits 7:6 are ignored and STATUS bit2 reads 0.

Decomposition:
- Package uart_ctrl_pkg holds:
  - register offset constants (REG_ENC..REG_STATUS);
  - ENC/CMD/STATUS bit positions;
  - the FSM state typedef;
  - default constants.
- Sub-module uart_ctrl_chan owns one channel (shadow, active, FSM, err, lock). The top generates CH_NUM instances and contains the address decode and read mux.

Test Plan:
- Reset, then read ch0 regs 0–5 -> 0x60, 0x14, 0x00, 0xA5, 0x00, 0x00. Outputs: acq_num 15, parity_odd 1, parity_en 1.
- Ch1: write DIV_LO 0x64, DIV_HI 0x01, COMP 0x87, CMD 0x01 with ch_idle_i[1]=0 for 10 cycles -> pending=1, outputs unchanged. Raise idle -> after the next edge, baud_div 356, acq_num 15, commit_o[1] high exactly 1 cycle. Ch0 untouched.
- Ch0: write DIV_LO 0x01, DIV_HI 0x00, CMD 0x01, idle=1 -> err_o[0]=1, no commit_o, divisor still 20. Write STATUS 0x02 -> err_o[0]=0.
- Ch0: COMP 0xFF, commit -> acq_num_o 30 (no wrap).
- Ch0: commit pending, assert rst low mid-PEND -> all defaults, pending 0. Ch1 pending + idle same cycle as a ch1 COMP rewrite -> rewritten value committed.
- With UART_CTRL_LOCK_EN: CMD 0x80, write ENC 0x00 -> readback 0x60, STATUS 0x04. CMD 0x40 -> writes accepted again.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register map, bit positions, channel FSM state and reset defaults
// shared by the UART control register bank and its per-channel core.
package uart_ctrl_pkg;

  // Per-channel register offsets (addr[2:0])
  localparam logic [2:0] REG_ENC    = 3'd0;
  localparam logic [2:0] REG_DIV_LO = 3'd1;
  localparam logic [2:0] REG_DIV_HI = 3'd2;
  localparam logic [2:0] REG_COMP   = 3'd3;
  localparam logic [2:0] REG_CMD    = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;

  // ENC register bits
  localparam int unsigned ENC_BIG_END_BIT  = 7;
  localparam int unsigned ENC_PAR_EN_BIT   = 6;
  localparam int unsigned ENC_PAR_ODD_BIT  = 5;

  // CMD register bits
  localparam int unsigned CMD_COMMIT_BIT   = 0;
  localparam int unsigned CMD_LOCK_CLR_BIT = 6;
  localparam int unsigned CMD_LOCK_SET_BIT = 7;

  // STATUS register bits
  localparam int unsigned STATUS_PEND_BIT  = 0;
  localparam int unsigned STATUS_ERR_BIT   = 1;
  localparam int unsigned STATUS_LOCK_BIT  = 2;

  // Default build parameters
  localparam int unsigned DEF_CH_NUM   = 2;
  localparam int unsigned DEF_DIV_W    = 16;
  localparam int unsigned DEF_PERIOD_C = 20;
  localparam int unsigned DEF_UP_C     = 10;
  localparam int unsigned DEF_DOWN_C   = 5;

  // Reset values of the encoding bits
  localparam logic RST_BIG_END  = 1'b0;
  localparam logic RST_PAR_EN   = 1'b1;
  localparam logic RST_PAR_ODD  = 1'b1;

  // Per-channel commit FSM
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } chanState_t;

endpackage

// File: rtl/uart_ctrl_chan.sv
// uart_ctrl_chan: one UART channel's shadow/active configuration, commit FSM,
// sticky reject flag and (with UART_CTRL_LOCK_EN) configuration lock.
module uart_ctrl_chan
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W      = DEF_DIV_W,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
  parameter int unsigned DEF_UP     = DEF_UP_C,
  parameter int unsigned DEF_DOWN   = DEF_DOWN_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrEn,
  input  logic [2:0]       regSel,
  input  logic [7:0]       wdata,
  input  logic             chIdle,
  output logic [DIV_W-1:0] baudDiv,
  output logic [7:0]       bitComp,
  output logic [4:0]       acqNum,
  output logic             parityEn,
  output logic             bigEnd,
  output logic             parityOdd,
  output logic             commit,
  output logic             err,
  output logic             shBigEnd,
  output logic             shParEn,
  output logic             shParOdd,
  output logic [DIV_W-1:0] shDiv,
  output logic [7:0]       shComp,
  output logic             pending,
  output logic             locked
);

  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEF_PERIOD);
  localparam logic [7:0]       RST_COMP = {4'(DEF_UP), 4'(DEF_DOWN)};
  localparam logic [4:0]       RST_ACQ  = 5'(4'(DEF_UP)) + 5'(4'(DEF_DOWN));

  chanState_t       stateQ, stateNext_c;
  logic [DIV_W-1:0] shDivNext_c;
  logic [7:0]       shCompNext_c;
  logic             shBigEndNext_c, shParEnNext_c, shParOddNext_c;
  logic             cfgWr_c, cmdWr_c, errClr_c, shadowValid_c;
  logic             doCommit_c, doReject_c;

  assign cfgWr_c  = wrEn && !locked;
  assign cmdWr_c  = wrEn && (regSel == REG_CMD);
  assign errClr_c = wrEn && (regSel == REG_STATUS) && wdata[STATUS_ERR_BIT];
  assign pending  = (stateQ == ST_PEND);

  // Shadow set as seen after this edge's host write; commits use these values
  always_comb begin
    shDivNext_c    = shDiv;
    shCompNext_c   = shComp;
    shBigEndNext_c = shBigEnd;
    shParEnNext_c  = shParEn;
    shParOddNext_c = shParOdd;
    if (cfgWr_c) begin
      case (regSel)
        REG_ENC: begin
          shBigEndNext_c = wdata[ENC_BIG_END_BIT];
          shParEnNext_c  = wdata[ENC_PAR_EN_BIT];
          shParOddNext_c = wdata[ENC_PAR_ODD_BIT];
        end
        REG_DIV_LO: shDivNext_c[7:0]       = wdata;
        REG_DIV_HI: shDivNext_c[DIV_W-1:8] = wdata[DIV_W-9:0];
        REG_COMP:   shCompNext_c           = wdata;
        default: ;
      endcase
    end
    shadowValid_c = (shDivNext_c >= DIV_W'(2)) &&
                    ((5'(shCompNext_c[7:4]) + 5'(shCompNext_c[3:0])) != 5'd0);
  end

  // Commit FSM next state: wait for idle, then accept or reject the shadow set
  always_comb begin
    stateNext_c = stateQ;
    doCommit_c  = 1'b0;
    doReject_c  = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (cmdWr_c && wdata[CMD_COMMIT_BIT] && !locked) stateNext_c = ST_PEND;
      end
      ST_PEND: begin
        if (chIdle) begin
          stateNext_c = ST_IDLE;
          if (shadowValid_c) doCommit_c = 1'b1;
          else               doReject_c = 1'b1;
        end
      end
      default: stateNext_c = ST_IDLE;
    endcase
  end

  // Commit FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stateQ <= ST_IDLE;
    else      stateQ <= stateNext_c;
  end

  // Host-written shadow set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shDiv    <= RST_DIV;
      shComp   <= RST_COMP;
      shBigEnd <= RST_BIG_END;
      shParEn  <= RST_PAR_EN;
      shParOdd <= RST_PAR_ODD;
    end else begin
      shDiv    <= shDivNext_c;
      shComp   <= shCompNext_c;
      shBigEnd <= shBigEndNext_c;
      shParEn  <= shParEnNext_c;
      shParOdd <= shParOddNext_c;
    end
  end

  // Active set, commit pulse and sticky reject flag (a reject beats a clear)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baudDiv   <= RST_DIV;
      bitComp   <= RST_COMP;
      acqNum    <= RST_ACQ;
      bigEnd    <= RST_BIG_END;
      parityEn  <= RST_PAR_EN;
      parityOdd <= RST_PAR_ODD;
      commit    <= 1'b0;
      err       <= 1'b0;
    end else begin
      commit <= doCommit_c;
      if (doCommit_c) begin
        baudDiv   <= shDivNext_c;
        bitComp   <= shCompNext_c;
        acqNum    <= 5'(shCompNext_c[7:4]) + 5'(shCompNext_c[3:0]);
        bigEnd    <= shBigEndNext_c;
        parityEn  <= shParEnNext_c;
        parityOdd <= shParOddNext_c;
      end
      if (doReject_c)    err <= 1'b1;
      else if (errClr_c) err <= 1'b0;
    end
  end

`ifdef UART_CTRL_LOCK_EN
  // Configuration lock; clear wins over set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked <= 1'b0;
    end else if (cmdWr_c) begin
      if (wdata[CMD_LOCK_CLR_BIT])      locked <= 1'b0;
      else if (wdata[CMD_LOCK_SET_BIT]) locked <= 1'b1;
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: rtl/uart_ctrl_bank.sv
// uart_ctrl_bank: CH_NUM-channel UART control register bank. Decodes the
// byte-wide host bus into channels and muxes registered readback.
// Optional macro UART_CTRL_LOCK_EN enables the per-channel configuration lock.
module uart_ctrl_bank
  import uart_ctrl_pkg::*;
#(
  parameter  int unsigned CH_NUM     = DEF_CH_NUM,
  parameter  int unsigned DIV_W      = DEF_DIV_W,
  parameter  int unsigned DEF_PERIOD = DEF_PERIOD_C,
  parameter  int unsigned DEF_UP     = DEF_UP_C,
  parameter  int unsigned DEF_DOWN   = DEF_DOWN_C,
  localparam int unsigned AW         = ((3 + $clog2(CH_NUM)) < 4) ? 4 : (3 + $clog2(CH_NUM))
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en_i,
  input  logic                    rd_en_i,
  input  logic [AW-1:0]           addr_i,
  input  logic [7:0]              wdata_i,
  output logic [7:0]              rdata_o,
  input  logic [CH_NUM-1:0]       ch_idle_i,
  output logic [CH_NUM*DIV_W-1:0] baud_div_o,
  output logic [CH_NUM*8-1:0]     bit_comp_o,
  output logic [CH_NUM*5-1:0]     acq_num_o,
  output logic [CH_NUM-1:0]       parity_en_o,
  output logic [CH_NUM-1:0]       big_end_o,
  output logic [CH_NUM-1:0]       parity_odd_o,
  output logic [CH_NUM-1:0]       commit_o,
  output logic [CH_NUM-1:0]       err_o
);

  localparam int unsigned CW = AW - 3;

  logic [CW-1:0]       chSel;
  logic [2:0]          regSel;
  logic [CH_NUM*8-1:0] rdFlat;
  logic [7:0]          rdMux_c;

  assign chSel  = addr_i[AW-1:3];
  assign regSel = addr_i[2:0];

  for (genvar g = 0; g < CH_NUM; g++) begin : gCh
    logic             wrEn_c;
    logic             shBigEnd, shParEn, shParOdd, pending, locked;
    logic [DIV_W-1:0] shDiv;
    logic [7:0]       shComp;
    logic [7:0]       chByte_c;

    assign wrEn_c = wr_en_i && (chSel == CW'(g));

    uart_ctrl_chan #(
      .DIV_W      (DIV_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_UP     (DEF_UP),
      .DEF_DOWN   (DEF_DOWN)
    ) uChan (
      .clk       (clk),
      .rst       (rst),
      .wrEn      (wrEn_c),
      .regSel    (regSel),
      .wdata     (wdata_i),
      .chIdle    (ch_idle_i[g]),
      .baudDiv   (baud_div_o[g*DIV_W +: DIV_W]),
      .bitComp   (bit_comp_o[g*8 +: 8]),
      .acqNum    (acq_num_o[g*5 +: 5]),
      .parityEn  (parity_en_o[g]),
      .bigEnd    (big_end_o[g]),
      .parityOdd (parity_odd_o[g]),
      .commit    (commit_o[g]),
      .err       (err_o[g]),
      .shBigEnd  (shBigEnd),
      .shParEn   (shParEn),
      .shParOdd  (shParOdd),
      .shDiv     (shDiv),
      .shComp    (shComp),
      .pending   (pending),
      .locked    (locked)
    );

    // Readback byte of this channel's addressed register (shadow, not active)
    always_comb begin
      chByte_c = 8'h00;
      case (regSel)
        REG_ENC: begin
          chByte_c[ENC_BIG_END_BIT] = shBigEnd;
          chByte_c[ENC_PAR_EN_BIT]  = shParEn;
          chByte_c[ENC_PAR_ODD_BIT] = shParOdd;
        end
        REG_DIV_LO: chByte_c = shDiv[7:0];
        REG_DIV_HI: chByte_c = 8'(shDiv >> 8);
        REG_COMP:   chByte_c = shComp;
        REG_STATUS: begin
          chByte_c[STATUS_PEND_BIT] = pending;
          chByte_c[STATUS_ERR_BIT]  = err_o[g];
          chByte_c[STATUS_LOCK_BIT] = locked;
        end
        default: ;
      endcase
    end

    assign rdFlat[g*8 +: 8] = chByte_c;
  end

  // Channel select for readback; unpopulated channel indices read 0
  always_comb begin
    rdMux_c = 8'h00;
    for (int i = 0; i < CH_NUM; i++) begin
      if (chSel == CW'(i)) rdMux_c = rdFlat[i*8 +: 8];
    end
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rdata_o <= 8'h00;
    else if (rd_en_i) rdata_o <= rdMux_c;
  end

endmodule

// File: tb/tb_uart_ctrl_bank.sv
// tb_uart_ctrl_bank: directed scenarios plus randomized traffic checked
// against a transaction-level model of the two-channel register bank.
module tb_uart_ctrl_bank;

  logic        clk = 1'b0;
  logic        rst, wr_en_i, rd_en_i;
  logic [3:0]  addr_i;
  logic [7:0]  wdata_i, rdata_o;
  logic [1:0]  ch_idle_i;
  logic [31:0] baud_div_o;
  logic [15:0] bit_comp_o;
  logic [9:0]  acq_num_o;
  logic [1:0]  parity_en_o, big_end_o, parity_odd_o, commit_o, err_o;

  int nCmp = 0;
  int nBad = 0;

  // Reference model state
  logic [15:0] mDiv[2], aDiv[2];
  logic [7:0]  mComp[2], aComp[2], mEnc[2], aEnc[2];
  bit          mPend[2], mErr[2], mLock[2], mCommit[2];
  logic [7:0]  mRd;

  uart_ctrl_bank #(
    .CH_NUM(2), .DIV_W(16), .DEF_PERIOD(20), .DEF_UP(10), .DEF_DOWN(5)
  ) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .ch_idle_i(ch_idle_i),
    .baud_div_o(baud_div_o), .bit_comp_o(bit_comp_o), .acq_num_o(acq_num_o),
    .parity_en_o(parity_en_o), .big_end_o(big_end_o), .parity_odd_o(parity_odd_o),
    .commit_o(commit_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int c = 0; c < 2; c++) begin
      mDiv[c] = 16'd20; aDiv[c] = 16'd20;
      mComp[c] = 8'hA5; aComp[c] = 8'hA5;
      mEnc[c] = 8'h60;  aEnc[c] = 8'h60;
      mPend[c] = 0; mErr[c] = 0; mLock[c] = 0; mCommit[c] = 0;
    end
    mRd = 8'h00;
  endfunction

  function automatic logic [7:0] readReg(input logic [3:0] a);
    int c;
    c = int'(a[3]);
    case (a[2:0])
      3'd0: return mEnc[c];
      3'd1: return mDiv[c][7:0];
      3'd2: return mDiv[c][15:8];
      3'd3: return mComp[c];
      3'd5: return {5'b0, mLock[c], mErr[c], mPend[c]};
      default: return 8'h00;
    endcase
  endfunction

  // Apply one clock edge worth of host/idle activity to the model
  function automatic void modelEdge();
    int c, r, up, dn;
    bit hit;
    r = int'(addr_i[2:0]);
    if (rd_en_i) mRd = readReg(addr_i);
    for (c = 0; c < 2; c++) begin
      hit = wr_en_i && (int'(addr_i[3]) == c);
      mCommit[c] = 0;
      if (hit && !mLock[c]) begin
        case (r)
          0: mEnc[c] = wdata_i & 8'hE0;
          1: mDiv[c][7:0] = wdata_i;
          2: mDiv[c][15:8] = wdata_i;
          3: mComp[c] = wdata_i;
          default: ;
        endcase
      end
      if (hit && r == 5 && wdata_i[1]) mErr[c] = 0;
      if (mPend[c] && ch_idle_i[c]) begin
        mPend[c] = 0;
        up = int'(mComp[c][7:4]);
        dn = int'(mComp[c][3:0]);
        if (mDiv[c] >= 16'd2 && (up + dn) != 0) begin
          aDiv[c] = mDiv[c]; aComp[c] = mComp[c]; aEnc[c] = mEnc[c]; mCommit[c] = 1;
        end else begin
          mErr[c] = 1;
        end
      end else if (!mPend[c] && hit && r == 4 && wdata_i[0] && !mLock[c]) begin
        mPend[c] = 1;
      end
`ifdef UART_CTRL_LOCK_EN
      if (hit && r == 4) begin
        if (wdata_i[7]) mLock[c] = 1;
        if (wdata_i[6]) mLock[c] = 0;
      end
`endif
    end
  endfunction

  task automatic step(input bit wr, input bit rd, input logic [3:0] a,
                      input logic [7:0] d, input logic [1:0] idle);
    wr_en_i = wr; rd_en_i = rd; addr_i = a; wdata_i = d; ch_idle_i = idle;
    @(posedge clk);
    modelEdge();
    #1;
    wr_en_i = 1'b0; rd_en_i = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; addr_i = '0; wdata_i = '0; ch_idle_i = 2'b11;
    #2;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] expRd [6] = '{8'h60, 8'h14, 8'h00, 8'hA5, 8'h00, 8'h00};
    doReset();
    nCmp++; if (rdata_o !== 8'h00) begin nBad++; $display("FAIL reset_rdata got %h exp 00", rdata_o); end
    nCmp++; if (acq_num_o !== {5'd15, 5'd15}) begin nBad++; $display("FAIL reset_acq got %h exp 1ef", acq_num_o); end
    nCmp++; if (parity_odd_o !== 2'b11 || parity_en_o !== 2'b11 || big_end_o !== 2'b00) begin
      nBad++; $display("FAIL reset_enc got po=%b pe=%b be=%b exp 11 11 00", parity_odd_o, parity_en_o, big_end_o);
    end
    nCmp++; if (baud_div_o !== {16'd20, 16'd20} || commit_o !== 2'b00 || err_o !== 2'b00) begin
      nBad++; $display("FAIL reset_div got div=%h commit=%b err=%b", baud_div_o, commit_o, err_o);
    end
    for (int r = 0; r < 6; r++) begin
      step(0, 1, 4'(r), 8'h00, 2'b11);
      nCmp++; if (rdata_o !== expRd[r]) begin nBad++; $display("FAIL reset_read reg%0d got %h exp %h", r, rdata_o, expRd[r]); end
    end
  endtask

  task automatic test_commit_wait();
    step(1, 0, 4'h9, 8'h64, 2'b00);
    step(1, 0, 4'hA, 8'h01, 2'b00);
    step(1, 0, 4'hB, 8'h87, 2'b00);
    step(1, 0, 4'hC, 8'h01, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 4'h0, 8'h00, 2'b00);
      nCmp++; if (baud_div_o[31:16] !== 16'd20 || commit_o !== 2'b00) begin
        nBad++; $display("FAIL hold_pend cyc%0d got div=%0d commit=%b exp 20 00", i, baud_div_o[31:16], commit_o);
      end
    end
    step(0, 1, 4'hD, 8'h00, 2'b00);
    nCmp++; if (rdata_o !== 8'h01) begin nBad++; $display("FAIL pend_status got %h exp 01", rdata_o); end
    step(0, 0, 4'h0, 8'h00, 2'b10);
    nCmp++; if (baud_div_o[31:16] !== 16'd356 || acq_num_o[9:5] !== 5'd15 || bit_comp_o[15:8] !== 8'h87) begin
      nBad++; $display("FAIL commit_ch1 got div=%0d acq=%0d comp=%h exp 356 15 87", baud_div_o[31:16], acq_num_o[9:5], bit_comp_o[15:8]);
    end
    nCmp++; if (commit_o !== 2'b10) begin nBad++; $display("FAIL commit_pulse got %b exp 10", commit_o); end
    nCmp++; if (baud_div_o[15:0] !== 16'd20) begin nBad++; $display("FAIL ch0_untouched got %0d exp 20", baud_div_o[15:0]); end
    step(0, 0, 4'h0, 8'h00, 2'b11);
    nCmp++; if (commit_o !== 2'b00) begin nBad++; $display("FAIL commit_one_cycle got %b exp 00", commit_o); end
  endtask

  task automatic test_reject();
    step(1, 0, 4'h1, 8'h01, 2'b11);
    step(1, 0, 4'h2, 8'h00, 2'b11);
    step(1, 0, 4'h4, 8'h01, 2'b11);
    step(0, 0, 4'h0, 8'h00, 2'b11);
    nCmp++; if (err_o[0] !== 1'b1 || commit_o !== 2'b00 || baud_div_o[15:0] !== 16'd20) begin
      nBad++; $display("FAIL reject got err=%b commit=%b div=%0d exp 1 00 20", err_o[0], commit_o, baud_div_o[15:0]);
    end
    step(1, 0, 4'h5, 8'h02, 2'b11);
    nCmp++; if (err_o[0] !== 1'b0) begin nBad++; $display("FAIL err_clear got %b exp 0", err_o[0]); end
  endtask

  task automatic test_acq_max();
    step(1, 0, 4'h1, 8'h14, 2'b11);
    step(1, 0, 4'h3, 8'hFF, 2'b11);
    step(1, 0, 4'h4, 8'h01, 2'b11);
    step(0, 0, 4'h0, 8'h00, 2'b11);
    nCmp++; if (acq_num_o[4:0] !== 5'd30 || bit_comp_o[7:0] !== 8'hFF || commit_o[0] !== 1'b1) begin
      nBad++; $display("FAIL acq_max got acq=%0d comp=%h commit=%b exp 30 ff 1", acq_num_o[4:0], bit_comp_o[7:0], commit_o[0]);
    end
  endtask

  task automatic test_reset_mid_pend();
    step(1, 0, 4'h4, 8'h01, 2'b00);
    step(0, 1, 4'h5, 8'h00, 2'b00);
    nCmp++; if (rdata_o !== 8'h01) begin nBad++; $display("FAIL mid_pend_status got %h exp 01", rdata_o); end
    doReset();
    nCmp++; if (baud_div_o[15:0] !== 16'd20 || acq_num_o[4:0] !== 5'd15 || bit_comp_o[7:0] !== 8'hA5) begin
      nBad++; $display("FAIL mid_pend_defaults got div=%0d acq=%0d comp=%h", baud_div_o[15:0], acq_num_o[4:0], bit_comp_o[7:0]);
    end
    step(0, 1, 4'h5, 8'h00, 2'b11);
    nCmp++; if (rdata_o !== 8'h00) begin nBad++; $display("FAIL mid_pend_cleared got %h exp 00", rdata_o); end
    step(0, 1, 4'h1, 8'h00, 2'b11);
    nCmp++; if (rdata_o !== 8'h14) begin nBad++; $display("FAIL mid_pend_shadow got %h exp 14", rdata_o); end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 4'hC, 8'h01, 2'b00);
    step(1, 0, 4'hB, 8'h33, 2'b10);
    nCmp++; if (commit_o[1] !== 1'b1 || bit_comp_o[15:8] !== 8'h33 || acq_num_o[9:5] !== 5'd6) begin
      nBad++; $display("FAIL same_edge_rewrite got commit=%b comp=%h acq=%0d exp 1 33 6", commit_o[1], bit_comp_o[15:8], acq_num_o[9:5]);
    end
  endtask

  task automatic test_random();
    int expAcq;
    bit wr, rd;
    logic [3:0] a;
    logic [7:0] d;
    logic [1:0] idle;
    for (int cyc = 0; cyc < 600; cyc++) begin
      wr = ($urandom_range(0, 9) < 6);
      rd = ($urandom_range(0, 2) == 0);
      a = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))};
      d = 8'($urandom);
      if (a[2:0] == 3'd3 && $urandom_range(0, 7) == 0) d = 8'h00;
      if (a[2:0] == 3'd4) begin
        d[0] = ($urandom_range(0, 3) != 0);
        d[7] = ($urandom_range(0, 5) == 0);
        d[6] = ($urandom_range(0, 2) == 0);
      end
      idle = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
      step(wr, rd, a, d, idle);
      for (int c = 0; c < 2; c++) begin
        expAcq = int'(aComp[c][7:4]) + int'(aComp[c][3:0]);
        nCmp++; if (baud_div_o[c*16 +: 16] !== aDiv[c]) begin
          nBad++; $display("FAIL rand_div cyc%0d ch%0d got %h exp %h", cyc, c, baud_div_o[c*16 +: 16], aDiv[c]);
        end
        nCmp++; if (bit_comp_o[c*8 +: 8] !== aComp[c] || acq_num_o[c*5 +: 5] !== 5'(expAcq)) begin
          nBad++; $display("FAIL rand_comp cyc%0d ch%0d got %h/%0d exp %h/%0d", cyc, c, bit_comp_o[c*8 +: 8], acq_num_o[c*5 +: 5], aComp[c], expAcq);
        end
        nCmp++; if ({big_end_o[c], parity_en_o[c], parity_odd_o[c]} !== aEnc[c][7:5]) begin
          nBad++; $display("FAIL rand_enc cyc%0d ch%0d got %b%b%b exp %b", cyc, c, big_end_o[c], parity_en_o[c], parity_odd_o[c], aEnc[c][7:5]);
        end
        nCmp++; if (commit_o[c] !== mCommit[c] || err_o[c] !== mErr[c]) begin
          nBad++; $display("FAIL rand_flags cyc%0d ch%0d got commit=%b err=%b exp %b %b", cyc, c, commit_o[c], err_o[c], mCommit[c], mErr[c]);
        end
      end
      nCmp++; if (rdata_o !== mRd) begin
        nBad++; $display("FAIL rand_rdata cyc%0d got %h exp %h", cyc, rdata_o, mRd);
      end
    end
  endtask

`ifdef UART_CTRL_LOCK_EN
  task automatic test_lock();
    doReset();
    step(1, 0, 4'h4, 8'h80, 2'b11);
    step(1, 0, 4'h0, 8'h00, 2'b11);
    step(0, 1, 4'h0, 8'h00, 2'b11);
    nCmp++; if (rdata_o !== 8'h60) begin nBad++; $display("FAIL lock_enc got %h exp 60", rdata_o); end
    step(0, 1, 4'h5, 8'h00, 2'b11);
    nCmp++; if (rdata_o !== 8'h04) begin nBad++; $display("FAIL lock_status got %h exp 04", rdata_o); end
    step(1, 0, 4'h4, 8'h40, 2'b11);
    step(1, 0, 4'h0, 8'h00, 2'b11);
    step(0, 1, 4'h0, 8'h00, 2'b11);
    nCmp++; if (rdata_o !== 8'h00) begin nBad++; $display("FAIL unlock_enc got %h exp 00", rdata_o); end
  endtask
`endif

  initial begin
    rst = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; addr_i = '0; wdata_i = '0; ch_idle_i = 2'b11;
    test_reset();
    test_commit_wait();
    test_reject();
    test_acq_max();
    test_reset_mid_pend();
    test_back_to_back();
    test_random();
`ifdef UART_CTRL_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
